// File: rtl/lsu_sequencer.sv
// Load/store sequencer: legality check, req/ack memory transaction,
// lane steering for stores and extension of load data.
module lsu_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemEn,
    input  logic        MemRW,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic        DReq,
    output logic        DWe,
    output logic [31:0] DAddr,
    output logic [31:0] DWData,
    output logic [3:0]  DByteEn,
    input  logic        DAck,
    input  logic [31:0] DRData,
    output logic        Stall,
    output logic [31:0] RData,
    output logic        RValid,
    output logic        Fault,
    output logic [1:0]  FaultCause
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        TOFAULT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          is_store_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;

    logic          legal;
    logic          launch;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic [31:0]   shifted;
    logic [31:0]   load_ext;

    // Illegal encodings are treated exactly like misalignment
    always_comb begin
        legal = 1'b0;
        unique case (Funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~Addr[0];
            3'b010:  legal = (Addr[1:0] == 2'b00);
            3'b100:  legal = ~MemRW;
            3'b101:  legal = ~MemRW & ~Addr[0];
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        be = 4'b1111;
        wd = WData;
        if (MemRW) begin
            unique case (Funct3[1:0])
                2'b00: begin
                    be = 4'b0001 << Addr[1:0];
                    wd = {4{WData[7:0]}};
                end
                2'b01: begin
                    be = 4'b0011 << Addr[1:0];
                    wd = {2{WData[15:0]}};
                end
                default: begin
                    be = 4'b1111;
                    wd = WData;
                end
            endcase
        end
    end

    always_comb begin
        shifted  = DRData >> {off_q, 3'b000};
        load_ext = shifted;
        unique case (f3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_ext = {24'h0, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_ext = {16'h0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    assign launch = (state_q == IDLE) & MemEn & legal;

    always_comb begin
        state_d    = state_q;
        Stall      = 1'b0;
        Fault      = 1'b0;
        FaultCause = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (MemEn) begin
                    if (legal) begin
                        Stall   = 1'b1;
                        state_d = BUSY;
                    end else begin
                        Fault      = 1'b1;
                        FaultCause = MemRW ? 2'b10 : 2'b01;
                    end
                end
            end
            BUSY: begin
                Stall = 1'b1;
                if (DAck)
                    state_d = DONE;
                else if (cnt_q == LAST)
                    state_d = TOFAULT;
            end
            DONE: state_d = IDLE;
            TOFAULT: begin
                Fault      = 1'b1;
                FaultCause = 2'b11;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign DReq   = (state_q == BUSY);
    assign RValid = (state_q == DONE) & ~is_store_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_store_q <= 1'b0;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
            DWe        <= 1'b0;
            DAddr      <= 32'h0;
            DWData     <= 32'h0;
            DByteEn    <= 4'h0;
            RData      <= 32'h0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                DAddr      <= {Addr[31:2], 2'b00};
                DWe        <= MemRW;
                DByteEn    <= be;
                DWData     <= wd;
                is_store_q <= MemRW;
                f3_q       <= Funct3;
                off_q      <= Addr[1:0];
                cnt_q      <= '0;
            end else if (state_q == BUSY) begin
                if (DAck) begin
                    if (!is_store_q)
                        RData <= load_ext;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Scoreboard bench for lsu_sequencer: expected load results and faults
// are queued at launch and retired when the DUT pulses RValid/Fault.
module tb_lsu_sequencer;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemEn, MemRW;
    logic [2:0]  Funct3;
    logic [31:0] Addr, WData;
    logic        DReq, DWe;
    logic [31:0] DAddr, DWData;
    logic [3:0]  DByteEn;
    logic        DAck;
    logic [31:0] DRData;
    logic        Stall;
    logic [31:0] RData;
    logic        RValid, Fault;
    logic [1:0]  FaultCause;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] rd_q[$];
    logic [1:0]  fault_q[$];

    lsu_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemEn(MemEn), .MemRW(MemRW), .Funct3(Funct3),
        .Addr(Addr), .WData(WData),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr),
        .DWData(DWData), .DByteEn(DByteEn),
        .DAck(DAck), .DRData(DRData),
        .Stall(Stall), .RData(RData), .RValid(RValid),
        .Fault(Fault), .FaultCause(FaultCause)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [2:0] f3,
                                             input logic [31:0] a,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a[1:0] +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // Retire scoreboard entries on DUT output pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (RValid && Fault)
                check("rvalid_and_fault", 32'd1, 32'd0);
            if (RValid) begin
                if (rd_q.size() == 0)
                    check("rvalid_unexpected", 32'd1, 32'd0);
                else
                    check("rdata", RData, rd_q.pop_front());
            end
            if (Fault) begin
                if (fault_q.size() == 0)
                    check("fault_unexpected", 32'd1, 32'd0);
                else
                    check("fault_cause", {30'h0, FaultCause},
                          {30'h0, fault_q.pop_front()});
            end
        end
    end

    // ack_at: BUSY cycle carrying DAck (1..TO), 0 = never ack
    task automatic access(input logic rw, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wdat,
                          input int ack_at, input logic [31:0] word,
                          input logic legal);
        int hi;
        logic [3:0]  xbe;
        logic [31:0] xwd;
        xbe = 4'b1111;
        xwd = wdat;
        if (rw && f3[1:0] == 2'b00) begin
            xbe = 4'b0001 << a[1:0];
            xwd = {4{wdat[7:0]}};
        end else if (rw && f3[1:0] == 2'b01) begin
            xbe = 4'b0011 << a[1:0];
            xwd = {2{wdat[15:0]}};
        end
        @(posedge clk); #1;
        MemEn = 1'b1; MemRW = rw; Funct3 = f3; Addr = a; WData = wdat;
        if (!legal) begin
            fault_q.push_back(rw ? 2'b10 : 2'b01);
            @(negedge clk);
            check("ill_stall", {31'h0, Stall}, 32'd0);
            check("ill_dreq", {31'h0, DReq}, 32'd0);
            @(posedge clk); #1;
            MemEn = 1'b0;
            @(negedge clk);
            check("ill_noreq", {31'h0, DReq}, 32'd0);
            return;
        end
        if (!rw && ack_at > 0)
            rd_q.push_back(ld_model(f3, a, word));
        if (ack_at == 0)
            fault_q.push_back(2'b11);
        @(negedge clk);
        check("launch_stall", {31'h0, Stall}, 32'd1);
        check("launch_dreq", {31'h0, DReq}, 32'd0);
        hi = 0;
        for (int k = 1; k <= TO; k++) begin
            @(posedge clk); #1;
            MemEn  = 1'b0;
            DAck   = (k == ack_at);
            DRData = DAck ? word : $urandom;
            @(negedge clk);
            if (DReq)
                hi++;
            check("busy_stall", {31'h0, Stall}, 32'd1);
            check("daddr", DAddr, {a[31:2], 2'b00});
            check("dbyteen", {28'h0, DByteEn}, {28'h0, xbe});
            check("dwe", {31'h0, DWe}, {31'h0, rw});
            if (rw)
                check("dwdata", DWData, xwd);
            if (k == ack_at)
                break;
        end
        @(posedge clk); #1;
        DAck = 1'b0;
        @(negedge clk);
        check("end_dreq", {31'h0, DReq}, 32'd0);
        check("end_stall", {31'h0, Stall}, 32'd0);
        check("dreq_cycles", hi, (ack_at > 0) ? ack_at : TO);
        if (rw)
            check("store_rvalid", {31'h0, RValid}, 32'd0);
    endtask

    initial begin
        logic [2:0]  rf3;
        logic [31:0] ra;
        rst_n = 1'b0;
        MemEn = 1'b0; MemRW = 1'b0; Funct3 = 3'b000;
        Addr = 32'h0; WData = 32'h0; DAck = 1'b0; DRData = 32'h0;
        #12;
        check("rst_dreq", {31'h0, DReq}, 32'd0);
        check("rst_stall", {31'h0, Stall}, 32'd0);
        check("rst_rdata", RData, 32'h0);
        check("rst_dbyteen", {28'h0, DByteEn}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        access(1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF, 1'b1);
        access(1'b0, 3'b000, 32'h203, 32'h0, 1, 32'h80FFFF7F, 1'b1);
        access(1'b0, 3'b100, 32'h203, 32'h0, 2, 32'h80FFFF7F, 1'b1);
        access(1'b0, 3'b001, 32'h202, 32'h0, 3, 32'h80FFFF7F, 1'b1);
        access(1'b1, 3'b000, 32'h302, 32'hA5, 1, 32'h0, 1'b1);
        check("rdata_hold", RData, 32'hFFFF80FF);
        access(1'b1, 3'b001, 32'h306, 32'h1234BEEF, 2, 32'h0, 1'b1);
        access(1'b1, 3'b010, 32'h308, 32'hCAFEF00D, 1, 32'h0, 1'b1);

        access(1'b1, 3'b010, 32'h401, 32'h0, 1, 32'h0, 1'b0);
        access(1'b0, 3'b001, 32'h401, 32'h0, 1, 32'h0, 1'b0);
        access(1'b0, 3'b011, 32'h400, 32'h0, 1, 32'h0, 1'b0);
        access(1'b1, 3'b100, 32'h400, 32'h0, 1, 32'h0, 1'b0);

        access(1'b0, 3'b010, 32'h600, 32'h0, 0, 32'h0, 1'b1);
        access(1'b0, 3'b010, 32'h604, 32'h0, TO, 32'h01020304, 1'b1);

        // Reset two cycles into BUSY
        @(posedge clk); #1;
        MemEn = 1'b1; MemRW = 1'b0; Funct3 = 3'b010; Addr = 32'h500;
        @(posedge clk); #1;
        MemEn = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("arst_dreq", {31'h0, DReq}, 32'd0);
        check("arst_stall", {31'h0, Stall}, 32'd0);
        check("arst_daddr", DAddr, 32'h0);
        check("arst_dwdata", DWData, 32'h0);
        check("arst_misc", {22'h0, DWe, DByteEn, RValid, Fault, FaultCause},
              32'h0);
        check("arst_rdata", RData, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 3'b010, 32'h700, 32'h0, 2, 32'h55AA1234, 1'b1);

        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 4))
                0: rf3 = 3'b000;
                1: rf3 = 3'b100;
                2: rf3 = 3'b001;
                3: rf3 = 3'b101;
                default: rf3 = 3'b010;
            endcase
            ra = $urandom;
            if (rf3[1:0] == 2'b01) ra[0] = 1'b0;
            if (rf3[1:0] == 2'b10) ra[1:0] = 2'b00;
            access(1'b0, rf3, ra, 32'h0, $urandom_range(1, TO),
                   $urandom, 1'b1);
        end

        @(posedge clk);
        @(negedge clk);
        check("rd_q_empty", rd_q.size(), 32'd0);
        check("fault_q_empty", fault_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_sequencer.md
# lsu_sequencer

Multi-cycle load/store sequencer between the RV32I core and a handshaked data memory. It consumes the decoded memory-access controls (MemRW, load/store enable, funct3) plus the ALU-computed address and the store data. It runs a request/acknowledge transaction, stalls the PC and pipeline until that transaction completes, and returns byte-, half- or word-extended load data for write-back (WBSel = 00). It raises a fault for misaligned or illegal accesses and for memory that never acknowledges.

## Interface
- TIMEOUT, 16, number of DReq-high cycles without DAck before a timeout fault; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- MemEn  input  1  current instruction is a load or store.
- MemRW  input  1  1 = store, 0 = load.
- Funct3  input  3  access size/sign, from Inst[14:12].
- Addr  input  32  effective address from the ALU.
- WData  input  32  store data (rs2).
- DReq  output  1  memory request.
- DWe  output  1  write strobe, valid with DReq.
- DAddr  output  32  word-aligned address, {Addr[31:2],2'b00}.
- DWData  output  32  lane-aligned store data.
- DByteEn  output  4  byte lane enables.
- DAck  input  1  memory acknowledge.
- DRData  input  32  memory read word, valid with DAck.
- Stall  output  1  hold the PC and pipeline.
- RData  output  32  extended load result.
- RValid  output  1  RData valid, one-cycle pulse.
- Fault  output  1  access fault, one-cycle pulse.
- FaultCause  output  2  01 load misaligned/illegal, 10 store misaligned/illegal, 11 timeout.

## Operation
- **States:** IDLE, BUSY, DONE, TOFAULT; state is encoded in registers.
- **Legality check** (combinational, IDLE only):
  - Funct3 = 010 requires Addr[1:0] = 00.
  - Funct3 = 001 or 101 requires Addr[0] = 0.
  - Funct3 = 000 or 100 is always aligned.
  - Loads with Funct3 011/110/111, and stores with Funct3 other than 000/001/010, are illegal and handled like misaligned.
- **IDLE:**
  - MemEn = 1 and legal: register DAddr, DWe = MemRW, DByteEn, DWData, and the size/sign/offset. Go to BUSY. Stall = 1 in this cycle.
  - MemEn = 1 and illegal: Fault = 1 and FaultCause = 01 (load) or 10 (store), both combinational in this cycle. Stall = 0, no request, stay in IDLE.
  - MemEn = 0: nothing happens.
- **BUSY:**
  - DReq = 1 and Stall = 1.
  - DAck = 1: capture the extended DRData into RData (loads only), then go to DONE.
  - Otherwise increment the wait counter. When the counter equals TIMEOUT-1 and DAck = 0, go to TOFAULT.
  - DAck takes priority over timeout in the same cycle.
- **DONE:** RValid = 1 for loads (0 for stores), Stall = 0. Go to IDLE unconditionally; MemEn is ignored here so the same instruction is not relaunched.
- **TOFAULT:** Fault = 1, FaultCause = 11, Stall = 0, DReq = 0. Go to IDLE.
- **Store lanes:**
  - SB: DByteEn = 0001 << Addr[1:0]; DWData = {4{WData[7:0]}}.
  - SH: DByteEn = 0011 << Addr[1:0]; DWData = {2{WData[15:0]}}.
  - SW: DByteEn = 1111; DWData = WData.
- **Loads:** DByteEn = 1111. Shift DRData right by 8×offset, then:
  - LB sign-extends bits [7:0]; LBU zero-extends them.
  - LH sign-extends bits [15:0]; LHU zero-extends them.
  - LW passes the word unchanged.
- RData holds its value until the next load completes.
- The wait counter has width clog2(TIMEOUT+1) and is cleared on entry to BUSY.
- DAck outside BUSY is ignored.

## Timing
- **Reset:** asserting rst_n low forces IDLE immediately, including mid-transaction. DReq drops asynchronously.
- **Reset values:** DReq 0, DWe 0, DAddr 0, DWData 0, DByteEn 0, RData 0, RValid 0, Fault 0, FaultCause 00, Stall 0.
- **Handshake:**
  - DReq and DAddr/DWe/DWData/DByteEn are driven from registers and stay stable while DReq is high.
  - DReq falls in the cycle after DAck is sampled.
  - DAck is assumed to be a single-cycle pulse.
- **Latency:** the launch cycle is T.
  - DReq rises at T+1.
  - An ack at T+k gives DONE and RValid at T+k+1.
  - Minimum: 3 cycles per memory instruction, with Stall high at T and T+1.
- **Back-to-back accesses:** a new memory instruction appears in the cycle after DONE and is launched from IDLE. There is no extra bubble beyond DONE.
- **Timeout:** DReq is high for exactly TIMEOUT cycles. Fault pulses in the following cycle.
- Fault and RValid are never asserted together.

## Test plan
- **Aligned LW hit:** Addr = 0x100, Funct3 = 010, MemEn = 1, DAck one cycle after DReq with DRData = 0xDEADBEEF → DAddr = 0x100, DByteEn = 1111, Stall high 2 cycles, RValid pulse with RData = 0xDEADBEEF, total 3 cycles.
- **LB vs LBU, offset 3:** DRData = 0x80FF_FF7F, Addr = 0x203.
  - LB → RData = 0xFFFFFF80.
  - LBU → RData = 0x00000080.
  - Also check LH at Addr = 0x202 → 0xFFFF80FF.
- **SB at offset 2:** Addr = 0x302, WData = 0x000000A5 → DByteEn = 0100, DWData = 0xA5A5A5A5, DWe = 1, RValid stays 0.
- **Misaligned accesses:**
  - SW at Addr = 0x401 → same-cycle Fault with FaultCause = 10, Stall = 0, DReq never rises.
  - LH at Addr = 0x401 → FaultCause = 01.
- **Timeout, TIMEOUT = 4, no DAck:** DReq high exactly 4 cycles, then Fault with FaultCause = 11, then IDLE. Repeat with DAck in the 4th cycle → normal DONE, no Fault.
- **Reset mid-BUSY:** drop rst_n two cycles into BUSY → DReq = 0 and Stall = 0 immediately, all outputs at reset values. After release, the next LW completes normally.
